// File: rtl/goertzel_pkg.sv
// goertzel_pkg
// Shared definitions for the multi-bin Goertzel engine:
//   - Q-format helpers for the Q2.(CW-2) coefficients
//   - bin-index width derivation (bw_of)
//   - output streaming FSM state encoding
//   - ready-made coefficients for the k/N = 1/6 bin at CW = 16
// Optional build macro used by the design: GOERTZEL_ROUND_EN
// (round-half-up on every arithmetic shift instead of floor).
package goertzel_pkg;

  // Reference coefficient width and its fractional bit count.
  localparam int CW_DEFAULT = 16;
  localparam int CFRAC      = CW_DEFAULT - 2;

  // Fractional bits of a Q2.(cw-2) coefficient.
  function automatic int cfrac_of(input int cw);
    return cw - 2;
  endfunction

  // Width of a bin index; never narrower than one bit.
  function automatic int bw_of(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // Result streaming FSM.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_e;

  // 2cos(2*pi/6) = 1.0 and sin(2*pi/6) = 0.8660 in Q2.14.
  localparam logic signed [CW_DEFAULT-1:0] COS2_K1_6 = 16'sd16384;
  localparam logic signed [CW_DEFAULT-1:0] SIN_K1_6  = 16'sd14189;

endpackage

// File: rtl/goertzel_bin_core.sv
// goertzel_bin_core
// One Goertzel bin: second-order recursion s = x + cos2*s1 - s2, capture of
// the final state pair at block end, and the re/im result computation.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_x              signed input sample (IW)
//   i_accept         sample is consumed this cycle
//   i_last           consumed sample is the last of the block
//   i_cos2, i_sin    active coefficients, Q2.(CW-2)
//   o_re, o_im       result from the last captured block (combinational,
//                    registered by the parent)
// Build macro: GOERTZEL_ROUND_EN selects round-half-up shifts.
module goertzel_bin_core
  import goertzel_pkg::*;
#(
  parameter int IW = 12,
  parameter int OW = 24,
  parameter int CW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic signed [IW-1:0] i_x,
  input  logic                 i_accept,
  input  logic                 i_last,
  input  logic signed [CW-1:0] i_cos2,
  input  logic signed [CW-1:0] i_sin,
  output logic signed [OW-1:0] o_re,
  output logic signed [OW-1:0] o_im
);

  localparam int FRAC = cfrac_of(CW);
  localparam int PW   = CW + OW;

  // Rounding offsets are zero in the floor build so one datapath serves both.
`ifdef GOERTZEL_ROUND_EN
  localparam logic signed [PW-1:0] RND_FRAC = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] RND_HALF = PW'(1) << (CW - 2);
`else
  localparam logic signed [PW-1:0] RND_FRAC = '0;
  localparam logic signed [PW-1:0] RND_HALF = '0;
`endif

  logic signed [OW-1:0] s1_q, s1_d, s2_q, s2_d;
  logic signed [OW-1:0] sn1_q, sn1_d, sn2_q, sn2_d;
  logic signed [CW-1:0] cos2_cap_q, cos2_cap_d, sin_cap_q, sin_cap_d;
  logic signed [PW-1:0] rec_prod, re_prod, im_prod;
  logic signed [OW-1:0] x_ext, s_new;
  logic                 unused_bits;

  // Full-precision signed product of a coefficient and a state word.
  function automatic logic signed [PW-1:0] mul_ext(input logic signed [CW-1:0] c,
                                                   input logic signed [OW-1:0] v);
    logic signed [PW-1:0] ce, ve;
    ce = {{OW{c[CW-1]}}, c};
    ve = {{CW{v[OW-1]}}, v};
    return ce * ve;
  endfunction

  // Recursion step. Taking OW bits starting at the shift amount is the
  // arithmetic shift followed by the two's-complement wrap to OW bits.
  always_comb begin
    x_ext    = OW'(i_x);
    rec_prod = mul_ext(i_cos2, s1_q) + RND_FRAC;
    s_new    = x_ext + rec_prod[FRAC +: OW] - s2_q;
  end

  // State update. On the last sample the new s and the old s1 are captured
  // together with the coefficients in use, so the result stays tied to the
  // block that produced it even though the active set changes right now.
  always_comb begin
    s1_d       = s1_q;
    s2_d       = s2_q;
    sn1_d      = sn1_q;
    sn2_d      = sn2_q;
    cos2_cap_d = cos2_cap_q;
    sin_cap_d  = sin_cap_q;
    if (i_accept) begin
      if (i_last) begin
        sn1_d      = s_new;
        sn2_d      = s1_q;
        cos2_cap_d = i_cos2;
        sin_cap_d  = i_sin;
        s1_d       = '0;
        s2_d       = '0;
      end else begin
        s2_d = s1_q;
        s1_d = s_new;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      sn1_q      <= '0;
      sn2_q      <= '0;
      cos2_cap_q <= '0;
      sin_cap_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      sn1_q      <= sn1_d;
      sn2_q      <= sn2_d;
      cos2_cap_q <= cos2_cap_d;
      sin_cap_q  <= sin_cap_d;
    end
  end

  // re uses cos2/2, hence one extra bit of shift.
  always_comb begin
    re_prod = mul_ext(cos2_cap_q, sn1_q) + RND_HALF;
    im_prod = mul_ext(sin_cap_q, sn1_q) + RND_FRAC;
    o_re    = re_prod[CW-1 +: OW] - sn2_q;
    o_im    = im_prod[FRAC +: OW];
  end

  // Product bits discarded by the shift and the wrap.
  assign unused_bits = ^{rec_prod[PW-1:FRAC+OW], rec_prod[FRAC-1:0],
                         re_prod[PW-1:CW-1+OW], re_prod[CW-2:0],
                         im_prod[PW-1:FRAC+OW], im_prod[FRAC-1:0]};

endmodule

// File: rtl/goertzel_multibin.sv
// goertzel_multibin
// NB parallel Goertzel bins over one AXI4-Stream sample stream, N samples per
// block. At each block end every bin's complex result is buffered and then
// streamed out one bin per beat with full backpressure.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready      sample input (tready is always 1)
//   m_axis_tdata                    {re, im} of the current bin
//   m_axis_tuser                    bin index
//   m_axis_tlast                    high on bin NB-1
//   m_axis_tvalid/tready            result handshake
//   i_cfg_we/bin/cos2/sin           shadow coefficient write port
//   o_overflow                      sticky: a result set was dropped
// Build macro: GOERTZEL_ROUND_EN selects round-half-up shifts in the bins.
module goertzel_multibin
  import goertzel_pkg::*;
#(
  parameter int  IW = 12,
  parameter int  OW = 24,
  parameter int  CW = 16,
  parameter int  NB = 4,
  parameter int  N  = 126,
  localparam int BW = bw_of(NB)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic signed [IW-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [2*OW-1:0]      m_axis_tdata,
  output logic [BW-1:0]        m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 i_cfg_we,
  input  logic [BW-1:0]        i_cfg_bin,
  input  logic signed [CW-1:0] i_cfg_cos2,
  input  logic signed [CW-1:0] i_cfg_sin,
  output logic                 o_overflow
);

  localparam int NW = $clog2(N);

  logic [NW-1:0]        n_q, n_d;
  logic                 blk_last;
  logic                 cap_q, cap_d;
  logic signed [CW-1:0] cos2_sh_q [NB];
  logic signed [CW-1:0] cos2_sh_d [NB];
  logic signed [CW-1:0] sin_sh_q  [NB];
  logic signed [CW-1:0] sin_sh_d  [NB];
  logic signed [CW-1:0] cos2_act_q [NB];
  logic signed [CW-1:0] cos2_act_d [NB];
  logic signed [CW-1:0] sin_act_q  [NB];
  logic signed [CW-1:0] sin_act_d  [NB];
  logic signed [OW-1:0] bin_re [NB];
  logic signed [OW-1:0] bin_im [NB];
  logic [2*OW-1:0]      res_q [NB];
  logic [2*OW-1:0]      res_d [NB];
  out_state_e           state_q, state_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic                 hs, last_hs, drop, load;

  assign s_axis_tready = 1'b1;
  assign blk_last      = s_axis_tvalid && (n_q == NW'(N - 1));

  // Sample counter; cap_q marks the cycle after a block end, when the bins'
  // captured results are ready to be registered.
  always_comb begin
    n_d   = n_q;
    cap_d = blk_last;
    if (s_axis_tvalid) begin
      n_d = blk_last ? '0 : n_q + NW'(1);
    end
  end

  // Shadow registers take writes at any time; the active set copies the
  // shadow set only at a block end. A write landing on that same edge sits in
  // the shadow until the next block end because the copy reads the old value.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      cos2_sh_d[b]  = cos2_sh_q[b];
      sin_sh_d[b]   = sin_sh_q[b];
      cos2_act_d[b] = cos2_act_q[b];
      sin_act_d[b]  = sin_act_q[b];
      if (i_cfg_we && (i_cfg_bin == BW'(b))) begin
        cos2_sh_d[b] = i_cfg_cos2;
        sin_sh_d[b]  = i_cfg_sin;
      end
      if (blk_last) begin
        cos2_act_d[b] = cos2_sh_q[b];
        sin_act_d[b]  = sin_sh_q[b];
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bin
    goertzel_bin_core #(
      .IW (IW),
      .OW (OW),
      .CW (CW)
    ) u_core (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_x      (s_axis_tdata),
      .i_accept (s_axis_tvalid),
      .i_last   (blk_last),
      .i_cos2   (cos2_act_q[b]),
      .i_sin    (sin_act_q[b]),
      .o_re     (bin_re[b]),
      .o_im     (bin_im[b])
    );
  end

  // Output FSM. A new set is judged on its load cycle: it is dropped if a
  // transfer is still in progress and is not finishing on this very cycle,
  // which leaves the set being sent untouched.
  always_comb begin
    hs      = (state_q == SEND) && m_axis_tready;
    last_hs = hs && (idx_q == BW'(NB - 1));
    drop    = cap_q && (state_q == SEND) && !last_hs;
    load    = cap_q && !drop;
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q | drop;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (last_hs) begin
          state_d = load ? SEND : IDLE;
          idx_d   = '0;
        end else if (hs) begin
          idx_d = idx_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      res_d[b] = res_q[b];
      if (load) begin
        res_d[b] = {bin_re[b], bin_im[b]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_q     <= '0;
      cap_q   <= 1'b0;
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        cos2_sh_q[b]  <= '0;
        sin_sh_q[b]   <= '0;
        cos2_act_q[b] <= '0;
        sin_act_q[b]  <= '0;
        res_q[b]      <= '0;
      end
    end else begin
      n_q     <= n_d;
      cap_q   <= cap_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      for (int b = 0; b < NB; b++) begin
        cos2_sh_q[b]  <= cos2_sh_d[b];
        sin_sh_q[b]   <= sin_sh_d[b];
        cos2_act_q[b] <= cos2_act_d[b];
        sin_act_q[b]  <= sin_act_d[b];
        res_q[b]      <= res_d[b];
      end
    end
  end

  // Outputs read zero outside a transfer so nothing stale is presented.
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = (state_q == SEND) ? res_q[idx_q] : '0;
  assign m_axis_tuser  = (state_q == SEND) ? idx_q : '0;
  assign m_axis_tlast  = (state_q == SEND) && (idx_q == BW'(NB - 1));
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_goertzel_multibin.sv
// tb_goertzel_multibin
// Directed checks of goertzel_multibin with NB=2, N=12, CW=16 (floor build).
// Bin 0 uses 2cos=1.0 / sin=0.866 (k/N=1/6), bin 1 uses 2cos=0 / sin=1.0.
module tb_goertzel_multibin;

  localparam int IW = 12;
  localparam int OW = 24;
  localparam int CW = 16;
  localparam int NB = 2;
  localparam int N  = 12;
  localparam int BW = 1;

  logic                 i_clk;
  logic                 i_rst;
  logic signed [IW-1:0] s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [2*OW-1:0]      m_axis_tdata;
  logic [BW-1:0]        m_axis_tuser;
  logic                 m_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 i_cfg_we;
  logic [BW-1:0]        i_cfg_bin;
  logic signed [CW-1:0] i_cfg_cos2;
  logic signed [CW-1:0] i_cfg_sin;
  logic                 o_overflow;

  int vectorsApplied = 0;
  int miscompares    = 0;

  goertzel_multibin #(
    .IW (IW),
    .OW (OW),
    .CW (CW),
    .NB (NB),
    .N  (N)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_bin     (i_cfg_bin),
    .i_cfg_cos2    (i_cfg_cos2),
    .i_cfg_sin     (i_cfg_sin),
    .o_overflow    (o_overflow)
  );

  // Free-running clock, 10 time units per cycle
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop in case something never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete (observed timeout, expected finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint reOut();
    return longint'($signed(m_axis_tdata[2*OW-1:OW]));
  endfunction

  function automatic longint imOut();
    return longint'($signed(m_axis_tdata[OW-1:0]));
  endfunction

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectorsApplied++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input, then sample 1 unit after the clock edge
  task automatic applyStimulus(input int x, input logic valid);
    s_axis_tdata  = IW'(x);
    s_axis_tvalid = valid;
    @(posedge i_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic writeCoef(input int bin, input int cos2, input int sinv);
    i_cfg_we   = 1'b1;
    i_cfg_bin  = BW'(bin);
    i_cfg_cos2 = CW'(cos2);
    i_cfg_sin  = CW'(sinv);
    @(posedge i_clk);
    #1;
    i_cfg_we = 1'b0;
  endtask

  // One N-sample block: xFirst at n=0, xLast at n=N-1, zero elsewhere.
  // Optional idle gaps after each accepted sample but the last, and an
  // optional bin-0 coefficient write alongside sample 5.
  task automatic runBlock(input int xFirst, input int xLast, input bit gaps,
                          input bit cfgAt5, input int cfgCos, input int cfgSin);
    for (int n = 0; n < N; n++) begin
      if (cfgAt5 && n == 5) begin
        i_cfg_we   = 1'b1;
        i_cfg_bin  = '0;
        i_cfg_cos2 = CW'(cfgCos);
        i_cfg_sin  = CW'(cfgSin);
      end
      applyStimulus((n == 0) ? xFirst : ((n == N - 1) ? xLast : 0), 1'b1);
      i_cfg_we = 1'b0;
      if (gaps && n < N - 1) begin
        applyStimulus(777, 1'b0);
        if (n == N - 2) checkOutput("gap_noEarlyCapture", m_axis_tvalid, 0);
      end
    end
  endtask

  // Wait (bounded) for a result set and check both bins with tready high
  task automatic collectResults(input string tag, input longint re0, input longint im0,
                                input longint re1, input longint im1);
    int waitCycles;
    waitCycles = 0;
    m_axis_tready = 1'b1;
    while (m_axis_tvalid !== 1'b1 && waitCycles < 8) begin
      @(posedge i_clk);
      #1;
      waitCycles++;
    end
    checkOutput({tag, "_valid0"}, m_axis_tvalid, 1);
    checkOutput({tag, "_user0"}, m_axis_tuser, 0);
    checkOutput({tag, "_last0"}, m_axis_tlast, 0);
    checkOutput({tag, "_re0"}, reOut(), re0);
    checkOutput({tag, "_im0"}, imOut(), im0);
    @(posedge i_clk);
    #1;
    checkOutput({tag, "_valid1"}, m_axis_tvalid, 1);
    checkOutput({tag, "_user1"}, m_axis_tuser, 1);
    checkOutput({tag, "_last1"}, m_axis_tlast, 1);
    checkOutput({tag, "_re1"}, reOut(), re1);
    checkOutput({tag, "_im1"}, imOut(), im1);
    @(posedge i_clk);
    #1;
    checkOutput({tag, "_idle"}, m_axis_tvalid, 0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_tvalid"}, m_axis_tvalid, 0);
    checkOutput({tag, "_tlast"}, m_axis_tlast, 0);
    checkOutput({tag, "_tuser"}, m_axis_tuser, 0);
    checkOutput({tag, "_tdata"}, longint'(m_axis_tdata), 0);
    checkOutput({tag, "_overflow"}, o_overflow, 0);
  endtask

  // Load coefficients into the shadow set, then run a zero block so they
  // become active; that block's results are all zero.
  task automatic programAndPrime(input string tag);
    writeCoef(0, 16384, 14189);
    writeCoef(1, 0, 16384);
    runBlock(0, 0, 1'b0, 1'b0, 0, 0);
    collectResults(tag, 0, 0, 0, 0);
  endtask

  initial begin
    i_rst         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    i_cfg_we      = 1'b0;
    i_cfg_bin     = '0;
    i_cfg_cos2    = '0;
    i_cfg_sin     = '0;

    // Reset state
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    i_rst = 1'b0;
    checkCleared("reset");
    checkOutput("reset_tready", s_axis_tready, 1);

    programAndPrime("prime0");

    // Impulse at n=0: both bins end at re=1000, im=0
    runBlock(1000, 0, 1'b0, 1'b0, 0, 0);
    collectResults("impulse", 1000, 0, 1000, 0);

    // Impulse at n=N-1: sN1=x, sN2=0
    runBlock(0, 1000, 1'b0, 1'b0, 0, 0);
    collectResults("lastPos", 500, 866, 0, 1000);
    runBlock(0, -1000, 1'b0, 1'b0, 0, 0);
    collectResults("lastNeg", -500, -867, 0, -1000);

    // DC input: exact zero, first beat two cycles after the last sample
    for (int n = 0; n < N; n++) applyStimulus(100, 1'b1);
    checkOutput("dc_latency1", m_axis_tvalid, 0);
    applyStimulus(0, 1'b0);
    checkOutput("dc_latency2", m_axis_tvalid, 1);
    collectResults("dc", 0, 0, 0, 0);

    // tvalid gaps must not change anything
    runBlock(1000, 0, 1'b1, 1'b0, 0, 0);
    collectResults("gaps", 1000, 0, 1000, 0);

    // Backpressure across two block ends
    m_axis_tready = 1'b0;
    runBlock(0, 1000, 1'b0, 1'b0, 0, 0);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("bp_valid", m_axis_tvalid, 1);
    checkOutput("bp_reHeld", reOut(), 500);
    checkOutput("bp_ovfBefore", o_overflow, 0);
    runBlock(0, -1000, 1'b0, 1'b0, 0, 0);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("bp_ovfSet", o_overflow, 1);
    checkOutput("bp_userHeld", m_axis_tuser, 0);
    checkOutput("bp_reStable", reOut(), 500);
    checkOutput("bp_imStable", imOut(), 866);
    collectResults("bp", 500, 866, 0, 1000);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("bp_noSecondSet", m_axis_tvalid, 0);
    checkOutput("bp_ovfSticky", o_overflow, 1);

    // Coefficient write mid-block only applies to the next block
    runBlock(0, 1000, 1'b0, 1'b1, 0, 14189);
    collectResults("coefA", 500, 866, 0, 1000);
    runBlock(0, 1000, 1'b0, 1'b0, 0, 0);
    collectResults("coefB", 0, 866, 0, 1000);

    // Reset at sample 7 of a block
    for (int n = 0; n < 7; n++) applyStimulus((n == 0) ? 1000 : 0, 1'b1);
    i_rst = 1'b1;
    applyStimulus(0, 1'b0);
    i_rst = 1'b0;
    checkCleared("rstMid");
    programAndPrime("prime1");
    runBlock(1000, 0, 1'b0, 1'b0, 0, 0);
    collectResults("afterRstMid", 1000, 0, 1000, 0);

    // Reset while a result set is waiting on tready
    m_axis_tready = 1'b0;
    runBlock(0, 1000, 1'b0, 1'b0, 0, 0);
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("rstSend_pre", m_axis_tvalid, 1);
    i_rst = 1'b1;
    applyStimulus(0, 1'b0);
    i_rst = 1'b0;
    checkCleared("rstSend");
    m_axis_tready = 1'b1;
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("rstSend_noPartial", m_axis_tvalid, 0);
    programAndPrime("prime2");
    runBlock(1000, 0, 1'b0, 1'b0, 0, 0);
    collectResults("afterRstSend", 1000, 0, 1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/goertzel_multibin.md
Name: goertzel_multibin

Overview:
- Parametrised multi-bin Goertzel DFT engine that replaces the fixed k/N=1/6 single-bin filter.
- Runs NB independent second-order IIR recursions in parallel on one AXI4-Stream ADC sample stream.
- Each bin has a runtime-programmable 2cos/sin coefficient pair. Block length is N samples.
- At each block end it captures all bins and streams NB complex results to the PS with full backpressure.

Parameters:
- IW, 12: input sample width, signed.
- OW, 24: accumulator and result component width, signed, two's-complement wrap.
- CW, 16: coefficient width, signed Q2.(CW-2).
- NB, 4: number of bins, must be >= 1.
- N, 126: samples per block, must be >= 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  IW  signed ADC sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  constant 1.
- m_axis_tdata  out  2*OW  {re[OW-1:0], im[OW-1:0]} for the current bin.
- m_axis_tuser  out  BW  bin index, BW = max(1, clog2(NB)).
- m_axis_tlast  out  1  high on bin NB-1.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  PS ready.
- i_cfg_we  in  1  coefficient write strobe.
- i_cfg_bin  in  BW  bin to write.
- i_cfg_cos2  in  CW  2cos(2πk/N), Q2.(CW-2).
- i_cfg_sin  in  CW  sin(2πk/N), Q2.(CW-2).
- o_overflow  out  1  sticky flag: a result set was dropped.

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, o_overflow=0.
  - Sample counter n=0, all s1/s2 state=0.
  - Shadow and active coefficients=0.
- Sample acceptance:
  - A sample is consumed only when s_axis_tvalid=1. Cycles with tvalid=0 freeze n and all state.
  - Per bin b: p = (cos2[b]*s1) >>> (CW-2), floor. Then s = x + p - s2, truncated to OW bits.
  - State update: s2 <= s1, s1 <= s.
- Block end, i.e. accepted sample with n==N-1:
  - Capture sN1 = s (new value) and sN2 = s1 (old value) for every bin.
  - Clear s1, s2 and n to 0.
  - Copy the shadow coefficients to the active set.
- Results per bin:
  - re = ((cos2*sN1) >>> (CW-1)) - sN2.
  - im = (sin*sN1) >>> (CW-2).
  - Both truncated to OW bits and registered into an NB-entry result buffer on the cycle after capture.
- Coefficient writes:
  - i_cfg_we writes the shadow registers only. Active coefficients change only at a block boundary or reset.
  - A write coincident with block end does not take effect until the following boundary.
- Output FSM:
  - IDLE: tvalid=0. On buffer load go to SEND with idx=0.
  - SEND: tvalid=1, tuser=idx, tlast=(idx==NB-1). tdata is held stable while tready=0.
  - On tvalid&tready: idx++. After tlast is accepted go to IDLE.
  - A buffer load and the final tlast handshake in the same cycle go directly to SEND with idx=0.
- Latency: the first result is valid 2 cycles after the accepted sample n==N-1.
- Overflow:
  - A block ends while the FSM is in SEND and this is not the tlast-handshake cycle: the new results are discarded, o_overflow is set, and the old set is delivered intact.
  - o_overflow clears only on reset.
- Reset mid-block or mid-transfer: all state is cleared immediately, with no partial output.

Optional Feature:
- GOERTZEL_ROUND_EN defined:
  - Every `>>>` in the recursion and in the results adds 2^(shift-1) before shifting (round-half-up).
- Undefined: floor truncation as above.

Decomposition:
- Package goertzel_pkg holds:
  - Q-format helper constants: CFRAC = CW-2.
  - The BW derivation function.
  - Output FSM state encoding: IDLE, SEND.
  - Coefficient constants for common bins: cos2 for k/N=1/6 is 16384, sin for k/N=1/6 is 14189; both are for CW=16.
- Sub-module goertzel_bin_core: one bin's recursion with s1/s2 state, capture, and re/im computation. Instantiated NB times in a generate loop.

Test Plan:
- Impulse, N=12, bin0 cos2=16384 sin=14189, bin1 cos2=0 sin=16384: x=1000 at n=0 then 0.
  - Bin0 gives re=1000, im=0; bin1 gives re=1000, im=0.
  - tuser=0 then 1, tlast on bin 1.
- DC, N=12, bin0 cos2=16384: x=100 for the whole block.
  - re=0, im=0, both exact.
  - Result arrives 2 cycles after the 12th sample.
- tvalid gaps, N=12: the impulse test with tvalid toggled 1/0 every cycle.
  - Identical results to the gap-free run; capture occurs only on the 12th accepted sample.
- Backpressure, N=12: hold m_axis_tready=0 across two block ends, then release.
  - o_overflow=1.
  - The first block's results are delivered unchanged, with tdata stable throughout the stall.
- Coefficient change mid-block: write bin0 cos2=0 at sample 5 of block A.
  - Block A still uses 16384.
  - Block B's impulse result matches the cos2=0 case.
- Reset at sample 7, and reset again during SEND.
  - Outputs go to 0 the next cycle.
  - The following full block yields the correct impulse results.
